id_pipe: RTL and testbench
==========================

Name: id_pipe

Overview:
- Parametrised next-generation decode stage for the RV32I pipeline.
- Decodes OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD and STORE.
- Forwards operands from NUM_FWD later stages, detects load-use hazards and stalls on them, and resolves jumps and branches in ID.
- Drives a registered ID/EX output with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath width.
- NUM_FWD, 2, forwarding sources; index 0 is youngest (EX), higher indices are older.
- M_EXT, 0, 1 decodes RV32M (funct7=0000001 on OP); 0 flags those as illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- if_valid_i  in  1  fetch presents an instruction.
- if_pc_i  in  XLEN  instruction PC.
- if_inst_i  in  32  instruction word.
- id_ready_o  out  1  instruction accepted this cycle.
- rf_raddr1_o, rf_raddr2_o  out  5  regfile read addresses (combinational from if_inst_i).
- rf_rdata1_i, rf_rdata2_i  in  XLEN  regfile read data, same cycle.
- fwd_wreg_i  in  NUM_FWD  source i writes a register.
- fwd_wd_i  in  5*NUM_FWD  destination of source i.
- fwd_wdata_i  in  XLEN*NUM_FWD  result of source i.
- fwd_pend_i  in  NUM_FWD  source i result not yet available (load in flight).
- flush_i  in  1  kill all state from a later-stage redirect.
- ex_ready_i  in  1  EX accepts the output register.
- ex_valid_o  out  1  output register holds a valid instruction.
- ex_aluop_o  out  `AluOpBus  operation.
- ex_alusel_o  out  `AluSelBus  result class.
- ex_reg1_o, ex_reg2_o  out  XLEN  operands.
- ex_imm_o  out  XLEN  immediate (store offset, etc).
- ex_wd_o  out  5  destination register.
- ex_wreg_o  out  1  write enable.
- ex_link_o  out  XLEN  pc+4 for JAL/JALR.
- ex_illegal_o  out  1  undecodable instruction.
- br_flag_o  out  1  registered redirect pulse.
- br_target_o  out  XLEN  redirect target.

Behaviour:
- Reset (async, rst=1):
  - All ex_* outputs are 0; ex_valid_o=0.
  - br_flag_o=0, br_target_o=0.
  - FSM goes to RUN. id_ready_o=0 while rst is high.
- Operand selection, per source:
  - Address 0 always yields 0.
  - Otherwise the lowest-index i with fwd_wreg_i[i] and fwd_wd_i[i]==addr wins.
  - If that winning i has fwd_pend_i[i]=1, a hazard is raised.
  - With no forwarding match, the regfile data is used.
  - A source not read by the format takes imm.
  - AUIPC uses reg1=imm, reg2=pc.
- Load enable: load_en = !ex_valid_o || ex_ready_i.
- Accept: id_ready_o = load_en && !hazard && state==RUN, or load_en in DROP.
- On accept:
  - The output register loads the decoded fields; ex_valid_o=1.
  - In DROP, or when the instruction is illegal, it loads a bubble instead. An illegal instruction gives ex_valid_o=1, ex_illegal_o=1, ex_wreg_o=0.
- On load_en without accept: ex_valid_o=0 (bubble inserted).
- Without load_en: everything holds, including while ex_valid_o=1 and !ex_ready_i.
- Jumps and branches: on accept of JAL, JALR or a taken branch in RUN:
  - br_flag_o=1 next cycle, for exactly one cycle.
  - br_target_o is registered.
  - FSM moves RUN->DROP.
- Targets:
  - JAL: pc + sext(J-imm).
  - JALR: (rs1 + sext(I-imm)) with bit0 cleared.
  - Branch: pc + sext(B-imm).
- Branch conditions: signed and unsigned compares on the forwarded operands. A hazard on a branch/JALR operand stalls as for any other use.
- DROP state:
  - Discards exactly one accepted if_valid_i instruction (wrong-path), then returns to RUN.
  - Stays in DROP while !if_valid_i.
- flush_i:
  - Synchronous: next cycle ex_valid_o=0, br_flag_o=0, state=RUN.
  - The current input is not accepted (id_ready_o=0).
  - flush_i has priority over a simultaneous redirect or accept.
- Shift immediates: SLLI/SRLI/SRAI with bits[31:25] not in {0000000, 0100000} are illegal. SUB exists only on OP, not OP_IMM.
- Width rules: all sums are XLEN wrap-around. Immediates are sign-extended from bit 31 to XLEN.

Decomposition:
- Shared package/defines holds opcode, funct3/funct7, EXE_*_OP, EXE_RES_* and the new MUL/DIV/LOAD/STORE op codes.
- Sub-module id_fwd_mux (one instance per source) implements priority forwarding and hazard detection.
- Decode and FSM stay in id_pipe.

Test Plan:
- ADDI x1,x0,5 with fwd idle, ex_ready_i=1 -> next cycle ex_valid_o=1, reg1=0, reg2=5, wd=1, wreg=1.
- ADD x3,x1,x2 with fwd0 x1=0x10 and fwd1 x1=0x20 -> reg1=0x10 (youngest wins); rs=x0 matched by fwd -> 0.
- ADD x3,x1,x2 with fwd0 x1 pending -> id_ready_o=0, one bubble; pending cleared next cycle -> accepted, reg1=fwd data.
- BEQ x1,x1,-8 at pc 0x100 -> br_flag_o one cycle, target 0xF8; following instruction dropped, then normal flow.
- ex_ready_i=0 for 3 cycles with a valid output -> outputs stable, id_ready_o=0; flush_i during a stall -> ex_valid_o=0, state RUN.
- M_EXT=0, MUL x1,x2,x3 -> ex_illegal_o=1, wreg=0. Assert rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, function codes, ALU op/result codes.
package id_pipe_pkg;

  localparam int unsigned AluOpW  = 8;
  localparam int unsigned AluSelW = 3;

  // Major opcodes
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  // funct7
  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  // funct3 for OP / OP_IMM
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  // ALU operation codes
  localparam logic [AluOpW-1:0] ExeNopOp    = 8'h00;
  localparam logic [AluOpW-1:0] ExeAndOp    = 8'h24;
  localparam logic [AluOpW-1:0] ExeOrOp     = 8'h25;
  localparam logic [AluOpW-1:0] ExeXorOp    = 8'h26;
  localparam logic [AluOpW-1:0] ExeSllOp    = 8'h7c;
  localparam logic [AluOpW-1:0] ExeSrlOp    = 8'h02;
  localparam logic [AluOpW-1:0] ExeSraOp    = 8'h03;
  localparam logic [AluOpW-1:0] ExeSltOp    = 8'h2a;
  localparam logic [AluOpW-1:0] ExeSltuOp   = 8'h2b;
  localparam logic [AluOpW-1:0] ExeAddOp    = 8'h20;
  localparam logic [AluOpW-1:0] ExeSubOp    = 8'h22;
  localparam logic [AluOpW-1:0] ExeLuiOp    = 8'h0f;
  localparam logic [AluOpW-1:0] ExeAuipcOp  = 8'h17;
  localparam logic [AluOpW-1:0] ExeJalOp    = 8'h50;
  localparam logic [AluOpW-1:0] ExeJalrOp   = 8'h09;
  localparam logic [AluOpW-1:0] ExeBeqOp    = 8'h51;
  localparam logic [AluOpW-1:0] ExeBneOp    = 8'h52;
  localparam logic [AluOpW-1:0] ExeBltOp    = 8'h53;
  localparam logic [AluOpW-1:0] ExeBgeOp    = 8'h54;
  localparam logic [AluOpW-1:0] ExeBltuOp   = 8'h55;
  localparam logic [AluOpW-1:0] ExeBgeuOp   = 8'h56;
  localparam logic [AluOpW-1:0] ExeMulOp    = 8'h18;
  localparam logic [AluOpW-1:0] ExeMulhOp   = 8'h19;
  localparam logic [AluOpW-1:0] ExeMulhsuOp = 8'h1a;
  localparam logic [AluOpW-1:0] ExeMulhuOp  = 8'h1b;
  localparam logic [AluOpW-1:0] ExeDivOp    = 8'h1c;
  localparam logic [AluOpW-1:0] ExeDivuOp   = 8'h1d;
  localparam logic [AluOpW-1:0] ExeRemOp    = 8'h1e;
  localparam logic [AluOpW-1:0] ExeRemuOp   = 8'h1f;
  localparam logic [AluOpW-1:0] ExeLbOp     = 8'h60;
  localparam logic [AluOpW-1:0] ExeLhOp     = 8'h61;
  localparam logic [AluOpW-1:0] ExeLwOp     = 8'h62;
  localparam logic [AluOpW-1:0] ExeLbuOp    = 8'h64;
  localparam logic [AluOpW-1:0] ExeLhuOp    = 8'h65;
  localparam logic [AluOpW-1:0] ExeSbOp     = 8'h68;
  localparam logic [AluOpW-1:0] ExeShOp     = 8'h69;
  localparam logic [AluOpW-1:0] ExeSwOp     = 8'h6a;

  // Result classes
  localparam logic [AluSelW-1:0] ResNop        = 3'd0;
  localparam logic [AluSelW-1:0] ResLogic      = 3'd1;
  localparam logic [AluSelW-1:0] ResShift      = 3'd2;
  localparam logic [AluSelW-1:0] ResArith      = 3'd3;
  localparam logic [AluSelW-1:0] ResJumpBranch = 3'd4;
  localparam logic [AluSelW-1:0] ResLoadStore  = 3'd5;
  localparam logic [AluSelW-1:0] ResMul        = 3'd6;
  localparam logic [AluSelW-1:0] ResDiv        = 3'd7;

  typedef enum logic {StRun, StDrop} id_state_e;

  // 32-bit immediates, sign bit still at bit 31
  function automatic logic [31:0] imm_i(logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction
  function automatic logic [31:0] imm_j(logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Priority operand forwarding for one source register, with load-use hazard flag.
module id_fwd_mux #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic [4:0]              addr_i,
  input  logic [XLEN-1:0]         rf_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_pend_i,
  output logic [XLEN-1:0]         data_o,
  output logic                    hazard_o
);

  // Lowest-index (youngest) matching source wins; x0 is hardwired zero.
  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    if (addr_i == 5'd0) begin
      data_o = '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_wreg_i[i] && (fwd_wd_i[5*i +: 5] == addr_i)) begin
          data_o   = fwd_wdata_i[XLEN*i +: XLEN];
          hazard_o = fwd_pend_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_pipe.sv
// RV32I decode stage: decode, operand forwarding, load-use stall, branch resolve, ID/EX register.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter bit          M_EXT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid_i,
  input  logic [XLEN-1:0]         if_pc_i,
  input  logic [31:0]             if_inst_i,
  output logic                    id_ready_o,
  output logic [4:0]              rf_raddr1_o,
  output logic [4:0]              rf_raddr2_o,
  input  logic [XLEN-1:0]         rf_rdata1_i,
  input  logic [XLEN-1:0]         rf_rdata2_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_pend_i,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  output logic                    ex_valid_o,
  output logic [AluOpW-1:0]       ex_aluop_o,
  output logic [AluSelW-1:0]      ex_alusel_o,
  output logic [XLEN-1:0]         ex_reg1_o,
  output logic [XLEN-1:0]         ex_reg2_o,
  output logic [XLEN-1:0]         ex_imm_o,
  output logic [4:0]              ex_wd_o,
  output logic                    ex_wreg_o,
  output logic [XLEN-1:0]         ex_link_o,
  output logic                    ex_illegal_o,
  output logic                    br_flag_o,
  output logic [XLEN-1:0]         br_target_o
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic       is_op, bad_f7;

  assign opcode      = if_inst_i[6:0];
  assign rd          = if_inst_i[11:7];
  assign f3          = if_inst_i[14:12];
  assign f7          = if_inst_i[31:25];
  assign rf_raddr1_o = if_inst_i[19:15];
  assign rf_raddr2_o = if_inst_i[24:20];
  assign is_op       = (opcode == OpcOp);
  assign bad_f7      = is_op && (f7 != F7Zero);

  logic [AluOpW-1:0]  dec_aluop;
  logic [AluSelW-1:0] dec_alusel;
  logic [31:0]        imm32;
  logic dec_wreg, dec_illegal, use1, use2, is_jal, is_jalr, is_br, is_auipc;

  // Instruction decode
  always_comb begin
    dec_aluop   = ExeNopOp;
    dec_alusel  = ResNop;
    imm32       = '0;
    dec_wreg    = 1'b0;
    dec_illegal = 1'b0;
    use1        = 1'b0;
    use2        = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    is_br       = 1'b0;
    is_auipc    = 1'b0;
    case (opcode)
      OpcOpImm, OpcOp: begin
        dec_wreg = 1'b1;
        use1     = 1'b1;
        use2     = is_op;
        imm32    = is_op ? 32'd0 : imm_i(if_inst_i);
        if (is_op && (f7 == F7Mul)) begin
          if (M_EXT) begin
            dec_alusel = f3[2] ? ResDiv : ResMul;
            unique case (f3)
              3'b000:  dec_aluop = ExeMulOp;
              3'b001:  dec_aluop = ExeMulhOp;
              3'b010:  dec_aluop = ExeMulhsuOp;
              3'b011:  dec_aluop = ExeMulhuOp;
              3'b100:  dec_aluop = ExeDivOp;
              3'b101:  dec_aluop = ExeDivuOp;
              3'b110:  dec_aluop = ExeRemOp;
              default: dec_aluop = ExeRemuOp;
            endcase
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          unique case (f3)
            F3AddSub: begin
              dec_alusel = ResArith;
              if (is_op && (f7 == F7Alt)) dec_aluop = ExeSubOp;
              else if (bad_f7)             dec_illegal = 1'b1;
              else                         dec_aluop = ExeAddOp;
            end
            F3Sll: begin
              dec_alusel  = ResShift;
              dec_aluop   = ExeSllOp;
              dec_illegal = (f7 != F7Zero);
            end
            F3SrlSra: begin
              dec_alusel  = ResShift;
              dec_aluop   = (f7 == F7Alt) ? ExeSraOp : ExeSrlOp;
              dec_illegal = (f7 != F7Zero) && (f7 != F7Alt);
            end
            F3Slt:  begin dec_alusel = ResArith; dec_aluop = ExeSltOp;  dec_illegal = bad_f7; end
            F3Sltu: begin dec_alusel = ResArith; dec_aluop = ExeSltuOp; dec_illegal = bad_f7; end
            F3Xor:  begin dec_alusel = ResLogic; dec_aluop = ExeXorOp;  dec_illegal = bad_f7; end
            F3Or:   begin dec_alusel = ResLogic; dec_aluop = ExeOrOp;   dec_illegal = bad_f7; end
            default: begin dec_alusel = ResLogic; dec_aluop = ExeAndOp; dec_illegal = bad_f7; end
          endcase
          // Shift-immediate carries only the shamt
          if (!is_op && (f3 == F3Sll || f3 == F3SrlSra)) imm32 = {27'd0, if_inst_i[24:20]};
        end
      end
      OpcLui: begin
        dec_wreg = 1'b1; imm32 = imm_u(if_inst_i);
        dec_aluop = ExeLuiOp; dec_alusel = ResArith;
      end
      OpcAuipc: begin
        dec_wreg = 1'b1; imm32 = imm_u(if_inst_i); is_auipc = 1'b1;
        dec_aluop = ExeAuipcOp; dec_alusel = ResArith;
      end
      OpcJal: begin
        dec_wreg = 1'b1; imm32 = imm_j(if_inst_i); is_jal = 1'b1;
        dec_aluop = ExeJalOp; dec_alusel = ResJumpBranch;
      end
      OpcJalr: begin
        dec_wreg = 1'b1; use1 = 1'b1; imm32 = imm_i(if_inst_i); is_jalr = 1'b1;
        dec_aluop = ExeJalrOp; dec_alusel = ResJumpBranch;
        dec_illegal = (f3 != 3'b000);
      end
      OpcBranch: begin
        use1 = 1'b1; use2 = 1'b1; imm32 = imm_b(if_inst_i); is_br = 1'b1;
        dec_alusel = ResJumpBranch;
        unique case (f3)
          3'b000:  dec_aluop = ExeBeqOp;
          3'b001:  dec_aluop = ExeBneOp;
          3'b100:  dec_aluop = ExeBltOp;
          3'b101:  dec_aluop = ExeBgeOp;
          3'b110:  dec_aluop = ExeBltuOp;
          3'b111:  dec_aluop = ExeBgeuOp;
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcLoad: begin
        dec_wreg = 1'b1; use1 = 1'b1; imm32 = imm_i(if_inst_i); dec_alusel = ResLoadStore;
        unique case (f3)
          3'b000:  dec_aluop = ExeLbOp;
          3'b001:  dec_aluop = ExeLhOp;
          3'b010:  dec_aluop = ExeLwOp;
          3'b100:  dec_aluop = ExeLbuOp;
          3'b101:  dec_aluop = ExeLhuOp;
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcStore: begin
        use1 = 1'b1; use2 = 1'b1; imm32 = imm_s(if_inst_i); dec_alusel = ResLoadStore;
        unique case (f3)
          3'b000:  dec_aluop = ExeSbOp;
          3'b001:  dec_aluop = ExeShOp;
          3'b010:  dec_aluop = ExeSwOp;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal encodings read nothing, write nothing and never redirect
    if (dec_illegal) begin
      use1 = 1'b0; use2 = 1'b0; dec_wreg = 1'b0;
      is_jal = 1'b0; is_jalr = 1'b0; is_br = 1'b0; is_auipc = 1'b0;
    end
  end

  logic [XLEN-1:0] fwd1, fwd2, imm_x, reg1, reg2, target;
  logic            haz1, haz2, hazard, taken, redirect;

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .addr_i      (rf_raddr1_o),
    .rf_data_i   (rf_rdata1_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_pend_i  (fwd_pend_i),
    .data_o      (fwd1),
    .hazard_o    (haz1)
  );

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .addr_i      (rf_raddr2_o),
    .rf_data_i   (rf_rdata2_i),
    .fwd_wreg_i  (fwd_wreg_i),
    .fwd_wd_i    (fwd_wd_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_pend_i  (fwd_pend_i),
    .data_o      (fwd2),
    .hazard_o    (haz2)
  );

  assign imm_x  = XLEN'($signed(imm32));
  assign reg1   = is_auipc ? imm_x : (use1 ? fwd1 : imm_x);
  assign reg2   = is_auipc ? if_pc_i : (use2 ? fwd2 : imm_x);
  assign hazard = (use1 && haz1) || (use2 && haz2);

  // Branch condition and redirect target
  always_comb begin
    unique case (f3)
      3'b000:  taken = (fwd1 == fwd2);
      3'b001:  taken = (fwd1 != fwd2);
      3'b100:  taken = ($signed(fwd1) < $signed(fwd2));
      3'b101:  taken = ($signed(fwd1) >= $signed(fwd2));
      3'b110:  taken = (fwd1 < fwd2);
      default: taken = (fwd1 >= fwd2);
    endcase
    redirect = is_jal || is_jalr || (is_br && taken);
    target   = is_jalr ? ((fwd1 + imm_x) & ~XLEN'(1)) : (if_pc_i + imm_x);
  end

  id_state_e state_q, state_d;
  logic      load_en, accept;

  assign load_en    = !ex_valid_o || ex_ready_i;
  assign id_ready_o = !rst && !flush_i && load_en && ((state_q == StDrop) || !hazard);
  assign accept     = if_valid_i && id_ready_o;

  logic                valid_d, wreg_d, illegal_d, br_flag_d;
  logic [AluOpW-1:0]   aluop_d;
  logic [AluSelW-1:0]  alusel_d;
  logic [XLEN-1:0]     reg1_d, reg2_d, imm_d, link_d, br_target_d;
  logic [4:0]          wd_d;

  // Next-state for the FSM and the ID/EX register
  always_comb begin
    state_d     = state_q;
    br_flag_d   = 1'b0;
    br_target_d = br_target_o;
    valid_d     = ex_valid_o;
    aluop_d     = ex_aluop_o;
    alusel_d    = ex_alusel_o;
    reg1_d      = ex_reg1_o;
    reg2_d      = ex_reg2_o;
    imm_d       = ex_imm_o;
    wd_d        = ex_wd_o;
    wreg_d      = ex_wreg_o;
    link_d      = ex_link_o;
    illegal_d   = ex_illegal_o;
    if (flush_i) begin
      valid_d = 1'b0;
      state_d = StRun;
    end else if (load_en) begin
      // Bubble unless a real instruction is accepted below
      valid_d   = 1'b0;
      aluop_d   = ExeNopOp;
      alusel_d  = ResNop;
      reg1_d    = '0;
      reg2_d    = '0;
      imm_d     = '0;
      wd_d      = '0;
      wreg_d    = 1'b0;
      link_d    = '0;
      illegal_d = 1'b0;
      if (accept) begin
        if (state_q == StDrop) begin
          state_d = StRun;
        end else if (dec_illegal) begin
          valid_d   = 1'b1;
          illegal_d = 1'b1;
        end else begin
          valid_d  = 1'b1;
          aluop_d  = dec_aluop;
          alusel_d = dec_alusel;
          reg1_d   = reg1;
          reg2_d   = reg2;
          imm_d    = imm_x;
          wd_d     = dec_wreg ? rd : 5'd0;
          wreg_d   = dec_wreg;
          link_d   = if_pc_i + XLEN'(4);
          if (redirect) begin
            br_flag_d   = 1'b1;
            br_target_d = target;
            state_d     = StDrop;
          end
        end
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      ex_valid_o   <= 1'b0;
      ex_aluop_o   <= '0;
      ex_alusel_o  <= '0;
      ex_reg1_o    <= '0;
      ex_reg2_o    <= '0;
      ex_imm_o     <= '0;
      ex_wd_o      <= '0;
      ex_wreg_o    <= 1'b0;
      ex_link_o    <= '0;
      ex_illegal_o <= 1'b0;
      br_flag_o    <= 1'b0;
      br_target_o  <= '0;
    end else begin
      state_q      <= state_d;
      ex_valid_o   <= valid_d;
      ex_aluop_o   <= aluop_d;
      ex_alusel_o  <= alusel_d;
      ex_reg1_o    <= reg1_d;
      ex_reg2_o    <= reg2_d;
      ex_imm_o     <= imm_d;
      ex_wd_o      <= wd_d;
      ex_wreg_o    <= wreg_d;
      ex_link_o    <= link_d;
      ex_illegal_o <= illegal_d;
      br_flag_o    <= br_flag_d;
      br_target_o  <= br_target_d;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe with default parameters (XLEN=32, NUM_FWD=2, M_EXT=0).
module tb_id_pipe;
  import id_pipe_pkg::*;

  logic        clk, rst, if_valid_i, id_ready_o, flush_i, ex_ready_i;
  logic [31:0] if_pc_i, if_inst_i, rf_rdata1_i, rf_rdata2_i;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o, ex_wd_o;
  logic [1:0]  fwd_wreg_i, fwd_pend_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic        ex_valid_o, ex_wreg_o, ex_illegal_o, br_flag_o;
  logic [7:0]  ex_aluop_o;
  logic [2:0]  ex_alusel_o;
  logic [31:0] ex_reg1_o, ex_reg2_o, ex_imm_o, ex_link_o, br_target_o;

  int total = 0;
  int bad   = 0;

  id_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid_i   (if_valid_i),
    .if_pc_i      (if_pc_i),
    .if_inst_i    (if_inst_i),
    .id_ready_o   (id_ready_o),
    .rf_raddr1_o  (rf_raddr1_o),
    .rf_raddr2_o  (rf_raddr2_o),
    .rf_rdata1_i  (rf_rdata1_i),
    .rf_rdata2_i  (rf_rdata2_i),
    .fwd_wreg_i   (fwd_wreg_i),
    .fwd_wd_i     (fwd_wd_i),
    .fwd_wdata_i  (fwd_wdata_i),
    .fwd_pend_i   (fwd_pend_i),
    .flush_i      (flush_i),
    .ex_ready_i   (ex_ready_i),
    .ex_valid_o   (ex_valid_o),
    .ex_aluop_o   (ex_aluop_o),
    .ex_alusel_o  (ex_alusel_o),
    .ex_reg1_o    (ex_reg1_o),
    .ex_reg2_o    (ex_reg2_o),
    .ex_imm_o     (ex_imm_o),
    .ex_wd_o      (ex_wd_o),
    .ex_wreg_o    (ex_wreg_o),
    .ex_link_o    (ex_link_o),
    .ex_illegal_o (ex_illegal_o),
    .br_flag_o    (br_flag_o),
    .br_target_o  (br_target_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid_i  = 1'b0;
    if_pc_i     = 32'h0;
    if_inst_i   = 32'h00000013;
    rf_rdata1_i = 32'h0;
    rf_rdata2_i = 32'h0;
    fwd_wreg_i  = 2'b00;
    fwd_wd_i    = 10'h0;
    fwd_wdata_i = 64'h0;
    fwd_pend_i  = 2'b00;
    flush_i     = 1'b0;
    ex_ready_i  = 1'b1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] inst);
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
  endtask

  task automatic test_reset();
    present(32'h40, 32'h00500093);
    #1;
    total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%h exp=0", id_ready_o); end
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", ex_valid_o); end
    total++; if (br_flag_o !== 1'b0) begin bad++; $display("FAIL rst_brflag got=%h exp=0", br_flag_o); end
    total++; if (br_target_o !== 32'h0) begin bad++; $display("FAIL rst_target got=%h exp=0", br_target_o); end
    total++; if (ex_reg1_o !== 32'h0 || ex_wreg_o !== 1'b0) begin bad++; $display("FAIL rst_fields reg1=%h wreg=%h exp=0", ex_reg1_o, ex_wreg_o); end
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_addi();
    present(32'h40, 32'h00500093);  // addi x1,x0,5
    rf_rdata1_i = 32'h99; rf_rdata2_i = 32'h99;
    #1;
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL addi_ready got=%h exp=1", id_ready_o); end
    step();
    total++; if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL addi_valid got=%h exp=1", ex_valid_o); end
    total++; if (ex_reg1_o !== 32'h0) begin bad++; $display("FAIL addi_reg1 got=%h exp=0", ex_reg1_o); end
    total++; if (ex_reg2_o !== 32'h5) begin bad++; $display("FAIL addi_reg2 got=%h exp=5", ex_reg2_o); end
    total++; if (ex_wd_o !== 5'd1 || ex_wreg_o !== 1'b1) begin bad++; $display("FAIL addi_wd wd=%0d wreg=%h exp=1/1", ex_wd_o, ex_wreg_o); end
    total++; if (ex_aluop_o !== ExeAddOp) begin bad++; $display("FAIL addi_aluop got=%h exp=%h", ex_aluop_o, ExeAddOp); end
    present(32'h44, 32'hFFF00113);  // addi x2,x0,-1 back to back
    step();
    total++; if (ex_reg2_o !== 32'hFFFFFFFF || ex_wd_o !== 5'd2) begin bad++; $display("FAIL addi_b2b reg2=%h wd=%0d exp=ffffffff/2", ex_reg2_o, ex_wd_o); end
    total++; if (ex_imm_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffff", ex_imm_o); end
    idle();
    step();
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL idle_bubble got=%h exp=0", ex_valid_o); end
  endtask

  task automatic test_fwd();
    present(32'h80, 32'h002081B3);  // add x3,x1,x2
    rf_rdata1_i = 32'hAAAA; rf_rdata2_i = 32'hBBBB;
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h20, 32'h10};
    #1;
    total++; if (rf_raddr1_o !== 5'd1 || rf_raddr2_o !== 5'd2) begin bad++; $display("FAIL raddr got=%0d/%0d exp=1/2", rf_raddr1_o, rf_raddr2_o); end
    step();
    total++; if (ex_reg1_o !== 32'h10) begin bad++; $display("FAIL fwd_young got=%h exp=10", ex_reg1_o); end
    total++; if (ex_reg2_o !== 32'hBBBB) begin bad++; $display("FAIL fwd_rf got=%h exp=bbbb", ex_reg2_o); end
    fwd_wd_i = {5'd1, 5'd2}; fwd_wdata_i = {32'h20, 32'h30};
    step();
    total++; if (ex_reg1_o !== 32'h20 || ex_reg2_o !== 32'h30) begin bad++; $display("FAIL fwd_old reg1=%h reg2=%h exp=20/30", ex_reg1_o, ex_reg2_o); end
    present(32'h84, 32'h002001B3);  // add x3,x0,x2
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'hDEAD};
    step();
    total++; if (ex_reg1_o !== 32'h0 || ex_reg2_o !== 32'hBBBB) begin bad++; $display("FAIL fwd_x0 reg1=%h reg2=%h exp=0/bbbb", ex_reg1_o, ex_reg2_o); end
    idle();
  endtask

  task automatic test_hazard();
    present(32'hC0, 32'h002081B3);
    rf_rdata2_i = 32'h1234;
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_wdata_i = {32'h0, 32'h55}; fwd_pend_i = 2'b01;
    #1;
    total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL haz_ready got=%h exp=0", id_ready_o); end
    step();
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL haz_bubble got=%h exp=0", ex_valid_o); end
    fwd_pend_i = 2'b00; fwd_wdata_i = {32'h0, 32'h77};
    #1;
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL haz_release got=%h exp=1", id_ready_o); end
    step();
    total++; if (ex_valid_o !== 1'b1 || ex_reg1_o !== 32'h77) begin bad++; $display("FAIL haz_accept valid=%h reg1=%h exp=1/77", ex_valid_o, ex_reg1_o); end
    idle();
  endtask

  task automatic test_branch();
    present(32'h100, 32'hFE108CE3);  // beq x1,x1,-8
    rf_rdata1_i = 32'h7; rf_rdata2_i = 32'h7;
    step();
    total++; if (br_flag_o !== 1'b1) begin bad++; $display("FAIL beq_flag got=%h exp=1", br_flag_o); end
    total++; if (br_target_o !== 32'hF8) begin bad++; $display("FAIL beq_target got=%h exp=f8", br_target_o); end
    if_valid_i = 1'b0;
    step();
    total++; if (br_flag_o !== 1'b0 || ex_valid_o !== 1'b0) begin bad++; $display("FAIL beq_pulse flag=%h valid=%h exp=0/0", br_flag_o, ex_valid_o); end
    present(32'h104, 32'h00500093);  // wrong path
    step();
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL beq_drop got=%h exp=0", ex_valid_o); end
    present(32'hF8, 32'h00900213);  // addi x4,x0,9
    step();
    total++; if (ex_valid_o !== 1'b1 || ex_wd_o !== 5'd4) begin bad++; $display("FAIL beq_resume valid=%h wd=%0d exp=1/4", ex_valid_o, ex_wd_o); end
    present(32'h100, 32'hFE109CE3);  // bne x1,x1,-8: not taken
    step();
    total++; if (br_flag_o !== 1'b0 || ex_valid_o !== 1'b1) begin bad++; $display("FAIL bne_nt flag=%h valid=%h exp=0/1", br_flag_o, ex_valid_o); end
    present(32'h104, 32'h00900213);
    step();
    total++; if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL bne_next got=%h exp=1", ex_valid_o); end
    idle();
  endtask

  task automatic test_jalr();
    present(32'h300, 32'h005100E7);  // jalr x1,5(x2)
    rf_rdata1_i = 32'h102;
    step();
    total++; if (br_flag_o !== 1'b1 || br_target_o !== 32'h106) begin bad++; $display("FAIL jalr_target flag=%h tgt=%h exp=1/106", br_flag_o, br_target_o); end
    total++; if (ex_link_o !== 32'h304 || ex_wd_o !== 5'd1) begin bad++; $display("FAIL jalr_link link=%h wd=%0d exp=304/1", ex_link_o, ex_wd_o); end
    present(32'h304, 32'h00500093);
    step();
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL jalr_drop got=%h exp=0", ex_valid_o); end
    idle();
  endtask

  task automatic test_auipc_lui();
    present(32'h200, 32'h00001297);  // auipc x5,1
    step();
    total++; if (ex_reg1_o !== 32'h1000 || ex_reg2_o !== 32'h200 || ex_wd_o !== 5'd5) begin bad++; $display("FAIL auipc reg1=%h reg2=%h wd=%0d exp=1000/200/5", ex_reg1_o, ex_reg2_o, ex_wd_o); end
    present(32'h204, 32'h123452B7);  // lui x5,0x12345; rs1 field is x8
    fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd8}; fwd_pend_i = 2'b01;
    #1;
    total++; if (id_ready_o !== 1'b1) begin bad++; $display("FAIL lui_nohaz got=%h exp=1", id_ready_o); end
    step();
    total++; if (ex_reg1_o !== 32'h12345000 || ex_valid_o !== 1'b1) begin bad++; $display("FAIL lui reg1=%h valid=%h exp=12345000/1", ex_reg1_o, ex_valid_o); end
    idle();
  endtask

  task automatic test_illegal();
    present(32'h400, 32'h023100B3);  // mul x1,x2,x3
    step();
    total++; if (ex_valid_o !== 1'b1 || ex_illegal_o !== 1'b1 || ex_wreg_o !== 1'b0) begin bad++; $display("FAIL mul_illegal valid=%h ill=%h wreg=%h exp=1/1/0", ex_valid_o, ex_illegal_o, ex_wreg_o); end
    present(32'h404, 32'h40309093);  // slli with funct7=0100000
    step();
    total++; if (ex_illegal_o !== 1'b1) begin bad++; $display("FAIL slli_bad got=%h exp=1", ex_illegal_o); end
    present(32'h408, 32'h00309093);  // slli x1,x1,3
    step();
    total++; if (ex_illegal_o !== 1'b0 || ex_wreg_o !== 1'b1 || ex_reg2_o !== 32'h3) begin bad++; $display("FAIL slli_ok ill=%h wreg=%h reg2=%h exp=0/1/3", ex_illegal_o, ex_wreg_o, ex_reg2_o); end
    idle();
  endtask

  task automatic test_stall_flush();
    present(32'h40, 32'h00500093);
    step();
    ex_ready_i = 1'b0;
    present(32'h44, 32'h002081B3);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%h exp=0", i, id_ready_o); end
      step();
      total++; if (ex_valid_o !== 1'b1 || ex_reg2_o !== 32'h5 || ex_wd_o !== 5'd1) begin bad++; $display("FAIL stall_hold%0d valid=%h reg2=%h wd=%0d exp=1/5/1", i, ex_valid_o, ex_reg2_o, ex_wd_o); end
    end
    flush_i = 1'b1;
    #1;
    total++; if (id_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%h exp=0", id_ready_o); end
    step();
    flush_i = 1'b0;
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%h exp=0", ex_valid_o); end
    ex_ready_i = 1'b1;
    present(32'h48, 32'h00900213);
    step();
    total++; if (ex_valid_o !== 1'b1 || ex_wd_o !== 5'd4) begin bad++; $display("FAIL flush_run valid=%h wd=%0d exp=1/4", ex_valid_o, ex_wd_o); end
    present(32'h100, 32'hFE108CE3);  // taken beq with simultaneous flush
    rf_rdata1_i = 32'h7; rf_rdata2_i = 32'h7;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++; if (br_flag_o !== 1'b0 || ex_valid_o !== 1'b0) begin bad++; $display("FAIL flush_prio flag=%h valid=%h exp=0/0", br_flag_o, ex_valid_o); end
    present(32'h200, 32'h00900213);
    step();
    total++; if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL flush_nodrop got=%h exp=1", ex_valid_o); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    present(32'h40, 32'h00500093);
    step();
    ex_ready_i = 1'b0;
    step();
    rst = 1'b1;
    #1;
    total++; if (ex_valid_o !== 1'b0 || ex_reg2_o !== 32'h0 || ex_wd_o !== 5'd0) begin bad++; $display("FAIL rst_mid valid=%h reg2=%h wd=%0d exp=0/0/0", ex_valid_o, ex_reg2_o, ex_wd_o); end
    total++; if (br_target_o !== 32'h0 || id_ready_o !== 1'b0) begin bad++; $display("FAIL rst_mid_br tgt=%h ready=%h exp=0/0", br_target_o, id_ready_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    test_reset();
    test_addi();
    test_fwd();
    test_hazard();
    test_branch();
    test_jalr();
    test_auipc_lui();
    test_illegal();
    test_stall_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
